cacheline_adapter: RTL and testbench

Bridges the cache's line-wide physical-memory port to the 64-bit burst memory bus. It is the responder for the cache's pmem_read/pmem_write/pmem_address/pmem_wdata and returns pmem_rdata/pmem_resp. Each cache request becomes a 4-beat burst: a read deserialises beats into a 256-bit line, and a write serialises the line into beats.

---
 rtl/rv32i_types.sv | 28 ++
 rtl/beat_shift_reg.sv | 34 +++
 rtl/cacheline_adapter.sv | 113 +++++++++++
 tb/tb_cacheline_adapter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared type and constant package: line/beat geometry and the adapter FSM states.
package rv32i_types;

  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int BURST_LEN  = 4;
  localparam int CNT_W      = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adapter_state_t;

  // Returns line with beat slot idx replaced by beat.
  function automatic logic [LINE_WIDTH-1:0] insert_beat(
    input logic [LINE_WIDTH-1:0] line,
    input logic [CNT_W-1:0]      idx,
    input logic [BEAT_WIDTH-1:0] beat
  );
    logic [LINE_WIDTH-1:0] result;
    result = line;
    result[idx*BEAT_WIDTH +: BEAT_WIDTH] = beat;
    return result;
  endfunction

endpackage

// File: rtl/beat_shift_reg.sv
// Line-wide register with a beat-granular view: either loads a whole line
// (writeback) or drops one incoming beat into slot idx (fill). The beat at
// slot idx is always visible on beat.
module beat_shift_reg
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  insert,
  input  logic [BEAT_WIDTH-1:0] insert_data,
  input  logic [CNT_W-1:0]      idx,
  output logic [LINE_WIDTH-1:0] line,
  output logic [BEAT_WIDTH-1:0] beat
);

  // Line storage: whole-line load takes priority over a single-beat insert.
  // NOTE: this wide register is reset on purpose, because its selected beat
  // drives a top-level output that must read 0 out of reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      line <= '0;
    end else if (load) begin
      line <= load_line;
    end else if (insert) begin
      line <= insert_beat(line, idx, insert_data);
    end
  end

  assign beat = line[idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/cacheline_adapter.sv
// Cache line port <-> 64-bit burst bus bridge. Each line request becomes a
// 4-beat burst; fills are assembled beat by beat, writebacks are presented
// one beat at a time and advance on each burst_resp_i.
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int s_offset = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [31:0]           line_address_i,
  input  logic [LINE_WIDTH-1:0] line_wdata_i,
  output logic [LINE_WIDTH-1:0] line_rdata_o,
  output logic                  line_resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
  input  logic                  burst_resp_i,
  output logic                  burst_read_o,
  output logic                  burst_write_o,
  output logic [31:0]           burst_address_o,
  output logic [BEAT_WIDTH-1:0] burst_wdata_o
);

  adapter_state_t        state;
  logic [CNT_W-1:0]      beat_cnt;
  logic [LINE_WIDTH-1:0] shift_line;
  logic                  shift_load;
  logic                  shift_insert;
  logic                  last_beat;
  logic [31:0]           aligned_addr;
  logic                  unused_offset;

  // Byte-offset bits never reach the bus; the burst always starts on a line.
  assign aligned_addr  = {line_address_i[31:s_offset], {s_offset{1'b0}}};
  assign unused_offset = ^line_address_i[s_offset-1:0];

  // Writeback line is captured as the request is accepted; fill beats land
  // in the slot named by the beat counter.
  assign shift_load   = (state == IDLE) && line_write_i;
  assign shift_insert = (state == READ) && burst_resp_i;
  assign last_beat    = burst_resp_i && (beat_cnt == CNT_W'(BURST_LEN - 1));

  beat_shift_reg u_beats (
    .clk         (clk),
    .rst         (rst),
    .load        (shift_load),
    .load_line   (line_wdata_i),
    .insert      (shift_insert),
    .insert_data (burst_rdata_i),
    .idx         (beat_cnt),
    .line        (shift_line),
    .beat        (burst_wdata_o)
  );

  // Burst FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      line_rdata_o    <= '0;
      line_resp_o     <= 1'b0;
      burst_read_o    <= 1'b0;
      burst_write_o   <= 1'b0;
      burst_address_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          line_resp_o <= 1'b0;
          beat_cnt    <= '0;
          // Writeback wins over fill so a dirty victim leaves before refill.
          if (line_write_i) begin
            burst_address_o <= aligned_addr;
            burst_write_o   <= 1'b1;
            state           <= WRITE;
          end else if (line_read_i) begin
            burst_address_o <= aligned_addr;
            burst_read_o    <= 1'b1;
            state           <= READ;
          end
        end
        READ: begin
          if (burst_resp_i) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (last_beat) begin
            line_rdata_o <= insert_beat(shift_line, beat_cnt, burst_rdata_i);
            burst_read_o <= 1'b0;
            line_resp_o  <= 1'b1;
            state        <= DONE;
          end
        end
        WRITE: begin
          if (burst_resp_i) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (last_beat) begin
            burst_write_o <= 1'b0;
            line_resp_o   <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // Stray burst_resp_i here is a memory-side protocol error; ignore it.
          line_resp_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed scenarios with literal
// expectations, then randomized cache/memory traffic against a
// transaction-level model of the burst protocol.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_i;
  logic         line_write_i;
  logic [31:0]  line_address_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [31:0]  burst_address_o;
  logic [63:0]  burst_wdata_o;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk             (clk),
    .rst             (rst),
    .line_read_i     (line_read_i),
    .line_write_i    (line_write_i),
    .line_address_i  (line_address_i),
    .line_wdata_i    (line_wdata_i),
    .line_rdata_o    (line_rdata_o),
    .line_resp_o     (line_resp_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_address_o (burst_address_o),
    .burst_wdata_o   (burst_wdata_o)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 no transaction, 1 fill in flight, 2 writeback in flight, 3 completion cycle
  int           m_phase = 0;
  int           m_beats_seen = 0;
  logic [63:0]  m_fill_beats[4];
  logic [255:0] m_wline = '0;
  logic [255:0] m_fill  = '0;
  logic [31:0]  m_addr  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_beats_seen = 0; m_addr = '0; m_fill = '0;
    end else begin
      case (m_phase)
        0: begin
          if (line_write_i || line_read_i) begin
            m_addr = line_address_i & 32'hFFFF_FFE0;
            m_beats_seen = 0;
            if (line_write_i) begin
              m_wline = line_wdata_i;
              m_phase = 2;
            end else begin
              m_phase = 1;
            end
          end
        end
        1: if (burst_resp_i) begin
          m_fill_beats[m_beats_seen] = burst_rdata_i;
          m_beats_seen++;
          if (m_beats_seen == 4) begin
            m_fill = {m_fill_beats[3], m_fill_beats[2], m_fill_beats[1], m_fill_beats[0]};
            m_phase = 3;
          end
        end
        2: if (burst_resp_i) begin
          m_beats_seen++;
          if (m_beats_seen == 4) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_read",  burst_read_o,    m_phase == 1);
      check("m_write", burst_write_o,   m_phase == 2);
      check("m_resp",  line_resp_o,     m_phase == 3);
      check("m_addr",  burst_address_o, m_addr);
      if (m_phase == 2) check("m_wdata", burst_wdata_o, m_wline[64*m_beats_seen +: 64]);
      if (m_phase != 1) check("m_line", line_rdata_o, m_fill);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [255:0] t1_line;
  logic [255:0] t5_line;
  logic [63:0]  wexp[4];
  logic [63:0]  t3b[4];
  logic [6:0]   t3_pat;
  int           lat;
  int           n;

  initial begin
    rst = 1'b1; line_read_i = 0; line_write_i = 0; line_address_i = '0;
    line_wdata_i = '0; burst_rdata_i = '0; burst_resp_i = 0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_line",  line_rdata_o, 0);
    check("rst_resp",  line_resp_o, 0);
    check("rst_read",  burst_read_o, 0);
    check("rst_write", burst_write_o, 0);
    check("rst_addr",  burst_address_o, 0);
    check("rst_wdata", burst_wdata_o, 0);
    rst = 1'b0;

    // 1: basic fill
    t1_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_read_i = 1; line_address_i = 32'h0000_1234;
    tick();
    check("t1_addr", burst_address_o, 32'h0000_1220);
    check("t1_read", burst_read_o, 1);
    line_read_i = 0;
    for (int i = 0; i < 4; i++) begin
      burst_resp_i = 1; burst_rdata_i = {8{8'(8'h11 * (i + 1))}};
      tick();
    end
    burst_resp_i = 0;
    check("t1_resp", line_resp_o, 1);
    check("t1_line", line_rdata_o, t1_line);
    check("t1_read_drop", burst_read_o, 0);
    tick();
    check("t1_resp_width", line_resp_o, 0);

    // 2: writeback, each beat advances only on accept
    wexp = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
             64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    line_write_i = 1; line_address_i = 32'h8000_00FF;
    line_wdata_i = {wexp[3], wexp[2], wexp[1], wexp[0]};
    tick();
    line_write_i = 0; line_address_i = $urandom; line_wdata_i = {8{$urandom}};
    check("t2_addr", burst_address_o, 32'h8000_00E0);
    check("t2_write", burst_write_o, 1);
    check("t2_read", burst_read_o, 0);
    for (int i = 0; i < 4; i++) begin
      check("t2_wdata", burst_wdata_o, wexp[i]);
      tick();
      check("t2_wdata_hold", burst_wdata_o, wexp[i]);
      burst_resp_i = 1;
      tick();
      burst_resp_i = 0;
    end
    check("t2_resp", line_resp_o, 1);
    check("t2_write_drop", burst_write_o, 0);
    check("t2_line_kept", line_rdata_o, t1_line);
    tick();

    // 3: stalled fill, 3 idle cycles between beats 1 and 2
    for (int i = 0; i < 4; i++) t3b[i] = {$urandom, $urandom};
    t3_pat = 7'b1100011;
    line_read_i = 1; line_address_i = 32'h0000_2000;
    tick();
    line_read_i = 0;
    lat = 1; n = 0;
    for (int c = 0; c < 20 && !line_resp_o; c++) begin
      burst_resp_i = (c < 7) ? t3_pat[c] : 1'b0;
      if (burst_resp_i) begin
        burst_rdata_i = t3b[n];
        n++;
      end
      tick();
      lat++;
      if (!line_resp_o) begin
        check("t3_read_held", burst_read_o, 1);
        check("t3_addr_held", burst_address_o, 32'h0000_2000);
      end
    end
    burst_resp_i = 0;
    lat++;
    check("t3_latency", lat, 9);
    check("t3_line", line_rdata_o, {t3b[3], t3b[2], t3b[1], t3b[0]});
    tick();

    // 4: simultaneous request, writeback first, fill only after completion
    line_read_i = 1; line_write_i = 1; line_address_i = 32'h0000_3000;
    line_wdata_i = {8{$urandom}};
    tick();
    check("t4_write", burst_write_o, 1);
    check("t4_read", burst_read_o, 0);
    line_write_i = 0;
    for (int i = 0; i < 4; i++) begin
      burst_resp_i = 1; tick();
    end
    burst_resp_i = 0;
    check("t4_resp", line_resp_o, 1);
    tick();
    check("t4_no_read_yet", burst_read_o, 0);
    tick();
    check("t4_read_follows", burst_read_o, 1);
    line_read_i = 0;
    for (int i = 0; i < 4; i++) begin
      burst_resp_i = 1; burst_rdata_i = {$urandom, $urandom}; tick();
    end
    burst_resp_i = 0;
    check("t4_fill_resp", line_resp_o, 1);
    tick();

    // 5: reset mid-fill, then a clean fill at 0x40
    line_read_i = 1; line_address_i = 32'h0000_5000;
    tick();
    line_read_i = 0;
    for (int i = 0; i < 2; i++) begin
      burst_resp_i = 1; burst_rdata_i = {$urandom, $urandom}; tick();
    end
    burst_resp_i = 0; rst = 1;
    tick();
    rst = 0;
    check("t5_read", burst_read_o, 0);
    check("t5_resp", line_resp_o, 0);
    check("t5_addr", burst_address_o, 0);
    check("t5_line", line_rdata_o, 0);
    check("t5_wdata", burst_wdata_o, 0);
    t5_line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    line_read_i = 1; line_address_i = 32'h0000_0040;
    tick();
    line_read_i = 0;
    check("t5_addr40", burst_address_o, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      burst_resp_i = 1; burst_rdata_i = t5_line[64*i +: 64]; tick();
    end
    burst_resp_i = 0;
    check("t5_fill_resp", line_resp_o, 1);
    check("t5_fill_line", line_rdata_o,
          {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
           64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    tick();

    // 6: spurious responses in idle and in the completion cycle
    burst_resp_i = 1; burst_rdata_i = {$urandom, $urandom};
    tick();
    burst_resp_i = 0;
    check("t6_idle_read", burst_read_o, 0);
    check("t6_idle_write", burst_write_o, 0);
    check("t6_idle_resp", line_resp_o, 0);
    check("t6_idle_line", line_rdata_o, t5_line);
    line_read_i = 1; line_address_i = 32'h0000_0060;
    tick();
    line_read_i = 0;
    for (int i = 0; i < 4; i++) begin
      burst_resp_i = 1; burst_rdata_i = {$urandom, $urandom}; tick();
    end
    check("t6_done_resp", line_resp_o, 1);
    burst_resp_i = 1;
    tick();
    burst_resp_i = 0;
    check("t6_resp_width", line_resp_o, 0);
    check("t6_after_read", burst_read_o, 0);
    check("t6_after_write", burst_write_o, 0);
    tick();
    check("t6_still_idle", burst_read_o | burst_write_o | line_resp_o, 0);

    // Randomized traffic: cache drops its request in the completion cycle,
    // everything else (including mid-burst request/data noise) is random.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      burst_resp_i  = ($urandom_range(0, 9) < 6);
      burst_rdata_i = {$urandom, $urandom};
      line_address_i = $urandom;
      line_wdata_i   = {8{$urandom}};
      if (line_resp_o) begin
        line_read_i = 0; line_write_i = 0;
      end else begin
        line_read_i  = ($urandom_range(0, 9) < 3);
        line_write_i = ($urandom_range(0, 9) < 2);
      end
      tick();
    end
    rst = 0; line_read_i = 0; line_write_i = 0; burst_resp_i = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
